// File: rtl/ysyx_25040105_wbu_if.sv
// Writeback-unit bus: upstream instruction handshake, load response, regfile write port and commit trace.
// slave = the WBU side, master = the environment that feeds and observes it.
interface ysyx_25040105_wbu_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic          in_wen;
    logic          in_is_load;
    logic [2:0]    in_funct3;
    logic [1:0]    in_addr_lo;
    logic [DW-1:0] in_result;
    logic [DW-1:0] in_pc;

    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          commit_valid;
    logic [DW-1:0] commit_pc;
    logic          ld_err;

    modport slave (
        input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_result, in_pc,
        input  mem_rvalid, mem_rdata,
        output in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, ld_err
    );

    modport master (
        output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_result, in_pc,
        output mem_rvalid, mem_rdata,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, ld_err
    );
endinterface

// File: rtl/ysyx_25040105_wbu.sv
// Writeback unit: accepts one instruction, waits for load data if needed, then writes the regfile for one cycle.
// Optional same-cycle read bypass enabled by defining YSYX_25040105_WBU_BYPASS_EN.
module ysyx_25040105_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef YSYX_25040105_WBU_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] fwd_raddr1,
    input  logic [ADDR_WIDTH-1:0] fwd_raddr2,
    input  logic [DATA_WIDTH-1:0] fwd_rf_rdata1,
    input  logic [DATA_WIDTH-1:0] fwd_rf_rdata2,
    output logic [DATA_WIDTH-1:0] fwd_rdata1,
    output logic [DATA_WIDTH-1:0] fwd_rdata2,
`endif
    ysyx_25040105_wbu_if.slave    bus
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] rd_q;
    logic          wen_q;
    logic [2:0]    funct3_q;
    logic [1:0]    addr_lo_q;
    logic [DW-1:0] pc_q;

    logic          rf_wen_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;
    logic          commit_valid_q;
    logic [DW-1:0] commit_pc_q;
    logic          ld_err_q;

    logic [DW-1:0] load_data_d;
    logic          load_err_d;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.rf_wen       = rf_wen_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_pc    = commit_pc_q;
    assign bus.ld_err       = ld_err_q;

    // Lane select uses the address captured at accept; the memory returns the whole aligned word.
    assign load_byte = bus.mem_rdata[8*addr_lo_q +: 8];
    assign load_half = bus.mem_rdata[16*addr_lo_q[1] +: 16];

    always_comb begin
        load_data_d = '0;
        load_err_d  = 1'b0;
        case (funct3_q)
            3'd0: load_data_d = {{(DW-8){load_byte[7]}}, load_byte};
            3'd4: load_data_d = {{(DW-8){1'b0}}, load_byte};
            3'd1: begin
                load_data_d = {{(DW-16){load_half[15]}}, load_half};
                load_err_d  = addr_lo_q[0];
            end
            3'd5: begin
                load_data_d = {{(DW-16){1'b0}}, load_half};
                load_err_d  = addr_lo_q[0];
            end
            3'd2: begin
                load_data_d = bus.mem_rdata;
                load_err_d  = (addr_lo_q != 2'd0);
            end
            default: load_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_q           <= '0;
            wen_q          <= 1'b0;
            funct3_q       <= '0;
            addr_lo_q      <= '0;
            pc_q           <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            ld_err_q       <= 1'b0;
        end else begin
            rf_wen_q       <= 1'b0;
            commit_valid_q <= 1'b0;
            ld_err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        rd_q      <= bus.in_rd;
                        wen_q     <= bus.in_wen;
                        funct3_q  <= bus.in_funct3;
                        addr_lo_q <= bus.in_addr_lo;
                        pc_q      <= bus.in_pc;
                        if (bus.in_is_load) begin
                            state_q <= WAIT_MEM;
                        end else begin
                            // Non-load results are already final, so commit straight from the inputs.
                            state_q        <= COMMIT;
                            rf_wen_q       <= bus.in_wen & (bus.in_rd != '0);
                            rf_waddr_q     <= bus.in_rd;
                            rf_wdata_q     <= bus.in_result;
                            commit_valid_q <= 1'b1;
                            commit_pc_q    <= bus.in_pc;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        state_q        <= COMMIT;
                        rf_wen_q       <= wen_q & (rd_q != '0) & ~load_err_d;
                        rf_waddr_q     <= rd_q;
                        rf_wdata_q     <= load_data_d;
                        commit_valid_q <= 1'b1;
                        commit_pc_q    <= pc_q;
                        ld_err_q       <= load_err_d;
                    end
                end
                COMMIT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef YSYX_25040105_WBU_BYPASS_EN
    logic [AW-1:0] fwd_raddr [2];
    logic [DW-1:0] fwd_rf    [2];
    logic [DW-1:0] fwd_out   [2];

    assign fwd_raddr[0] = fwd_raddr1;
    assign fwd_raddr[1] = fwd_raddr2;
    assign fwd_rf[0]    = fwd_rf_rdata1;
    assign fwd_rf[1]    = fwd_rf_rdata2;
    assign fwd_rdata1   = fwd_out[0];
    assign fwd_rdata2   = fwd_out[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_out[gi] = (fwd_raddr[gi] == '0) ? '0 :
                             (rf_wen_q && (rf_waddr_q == fwd_raddr[gi])) ? rf_wdata_q :
                             fwd_rf[gi];
    end
`endif
endmodule

// File: tb/tb_ysyx_25040105_wbu.sv
// Directed, table-driven bench for the writeback unit plus hand-written reset/back-to-back sequences.
module tb_ysyx_25040105_wbu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ysyx_25040105_wbu_if #(.AW(5), .DW(32)) bus ();

`ifdef YSYX_25040105_WBU_BYPASS_EN
    logic [4:0]  fwd_raddr1 = '0, fwd_raddr2 = '0;
    logic [31:0] fwd_rf_rdata1 = '0, fwd_rf_rdata2 = '0;
    logic [31:0] fwd_rdata1, fwd_rdata2;
`endif

    ysyx_25040105_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef YSYX_25040105_WBU_BYPASS_EN
        .fwd_raddr1    (fwd_raddr1),
        .fwd_raddr2    (fwd_raddr2),
        .fwd_rf_rdata1 (fwd_rf_rdata1),
        .fwd_rf_rdata2 (fwd_rf_rdata2),
        .fwd_rdata1    (fwd_rdata1),
        .fwd_rdata2    (fwd_rdata2),
`endif
        .bus           (bus)
    );

    typedef struct {
        bit        ld;
        bit [4:0]  rd;
        bit        wen;
        bit [2:0]  f3;
        bit [1:0]  lo;
        bit [31:0] res;
        bit [31:0] rdata;
        int        waitc;
        bit        exp_wen;
        bit [31:0] exp_data;
        bit        exp_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_rd      = '0;
        bus.in_wen     = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_funct3  = '0;
        bus.in_addr_lo = '0;
        bus.in_result  = '0;
        bus.in_pc      = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    // Called at a negedge with the unit idle; returns at a negedge one cycle after COMMIT.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] pc;
        pc = 32'h8000_0000 + 32'(idx * 4);
        chk("ready_before", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid   = 1'b1;
        bus.in_rd      = v.rd;
        bus.in_wen     = v.wen;
        bus.in_is_load = v.ld;
        bus.in_funct3  = v.f3;
        bus.in_addr_lo = v.lo;
        bus.in_result  = v.res;
        bus.in_pc      = pc;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_result = 32'hBAD0_BAD0;
        if (v.ld) begin
            for (int w = 0; w < v.waitc; w++) begin
                chk("ready_in_wait", {31'd0, bus.in_ready}, 32'd0);
                chk("commit_in_wait", {31'd0, bus.commit_valid}, 32'd0);
                @(negedge clk);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = v.rdata;
            @(posedge clk);
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h5555_5555;
        end
        chk("commit_valid", {31'd0, bus.commit_valid}, 32'd1);
        chk("commit_pc", bus.commit_pc, pc);
        chk("rf_wen", {31'd0, bus.rf_wen}, {31'd0, v.exp_wen});
        chk("ld_err", {31'd0, bus.ld_err}, {31'd0, v.exp_err});
        chk("ready_in_commit", {31'd0, bus.in_ready}, 32'd0);
        if (v.exp_wen) begin
            chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, v.rd});
            chk("rf_wdata", bus.rf_wdata, v.exp_data);
        end
        $display("vec %0d: ld=%0d f3=%0d lo=%0d rd=%0d -> wen=%0d wdata=%h err=%0d commit=%0d",
                 idx, v.ld, v.f3, v.lo, v.rd, bus.rf_wen, bus.rf_wdata, bus.ld_err, bus.commit_valid);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after", {31'd0, bus.in_ready}, 32'd1);
        chk("pulse_clear", {29'd0, bus.commit_valid, bus.rf_wen, bus.ld_err}, 32'd0);
    endtask

    initial begin
        //           ld rd  wen f3 lo  result        rdata          wait exp_wen exp_data       err
        vecs[0]  = '{0, 5,  1, 0, 0, 32'h0000_1234, 32'h0,          0,  1, 32'h0000_1234, 0};
        vecs[1]  = '{1, 6,  1, 0, 3, 32'h0,         32'h80FF_0000,  4,  1, 32'hFFFF_FF80, 0};
        vecs[2]  = '{1, 7,  1, 5, 2, 32'h0,         32'h80FF_0000,  4,  1, 32'h0000_80FF, 0};
        vecs[3]  = '{0, 0,  1, 0, 0, 32'h0000_0099, 32'h0,          0,  0, 32'h0,         0};
        vecs[4]  = '{1, 8,  1, 2, 1, 32'h0,         32'h1234_5678,  1,  0, 32'h0,         1};
        vecs[5]  = '{1, 9,  1, 3, 0, 32'h0,         32'h1234_5678,  0,  0, 32'h0,         1};
        vecs[6]  = '{1, 10, 1, 4, 2, 32'h0,         32'h80FF_0000,  2,  1, 32'h0000_00FF, 0};
        vecs[7]  = '{1, 11, 1, 0, 2, 32'h0,         32'h80FF_0000,  0,  1, 32'hFFFF_FFFF, 0};
        vecs[8]  = '{1, 12, 1, 1, 2, 32'h0,         32'h80FF_0000,  1,  1, 32'hFFFF_80FF, 0};
        vecs[9]  = '{1, 13, 1, 2, 0, 32'h0,         32'hDEAD_BEEF,  3,  1, 32'hDEAD_BEEF, 0};
        vecs[10] = '{1, 14, 1, 1, 1, 32'h0,         32'h1234_8001,  0,  0, 32'h0,         1};
        vecs[11] = '{1, 15, 1, 5, 3, 32'h0,         32'h1234_8001,  0,  0, 32'h0,         1};
        vecs[12] = '{0, 3,  0, 0, 0, 32'hCAFE_0003, 32'h0,          0,  0, 32'h0,         0};
        vecs[13] = '{1, 0,  1, 2, 0, 32'h0,         32'h0000_0042,  1,  0, 32'h0,         0};
        vecs[14] = '{1, 16, 1, 6, 0, 32'h0,         32'h1111_1111,  0,  0, 32'h0,         1};
        vecs[15] = '{1, 17, 1, 1, 0, 32'h0,         32'h1234_8001,  0,  1, 32'hFFFF_8001, 0};
        vecs[16] = '{1, 18, 1, 0, 1, 32'h0,         32'h1234_8001,  0,  1, 32'hFFFF_FF80, 0};
        vecs[17] = '{1, 19, 1, 4, 0, 32'h0,         32'h1234_8001,  2,  1, 32'h0000_0001, 0};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_pulses", {29'd0, bus.commit_valid, bus.rf_wen, bus.ld_err}, 32'd0);
        chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("rst_wdata", bus.rf_wdata, 32'd0);
        chk("rst_pc", bus.commit_pc, 32'd0);
        $display("reset: ready=%0d commit=%0d wen=%0d", bus.in_ready, bus.commit_valid, bus.rf_wen);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Stray load response while idle must not commit anything.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("stray_rvalid", {30'd0, bus.commit_valid, bus.rf_wen}, 32'd0);
        chk("stray_ready", {31'd0, bus.in_ready}, 32'd1);
        $display("stray rvalid in IDLE: commit=%0d ready=%0d", bus.commit_valid, bus.in_ready);

        // Reset while waiting for load data drops the instruction.
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_wen = 1'b1;
        bus.in_rd = 5'd4; bus.in_funct3 = 3'd2; bus.in_addr_lo = 2'd0; bus.in_pc = 32'h100;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rstwait_busy", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("rstwait_nocommit", {30'd0, bus.commit_valid, bus.rf_wen}, 32'd0);
        chk("rstwait_idle", {31'd0, bus.in_ready}, 32'd1);
        $display("reset in WAIT_MEM: commit=%0d wen=%0d ready=%0d", bus.commit_valid, bus.rf_wen, bus.in_ready);
        idle_inputs();
        @(negedge clk);

        // in_valid held through COMMIT: second instruction waits until IDLE.
        bus.in_valid = 1'b1; bus.in_wen = 1'b1; bus.in_rd = 5'd1; bus.in_result = 32'h11; bus.in_pc = 32'h200;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_first", bus.rf_wdata, 32'h11);
        chk("b2b_noready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_rd = 5'd2; bus.in_result = 32'h22; bus.in_pc = 32'h204;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_gap", {31'd0, bus.commit_valid}, 32'd0);
        chk("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b2b_second_addr", {27'd0, bus.rf_waddr}, 32'd2);
        chk("b2b_second_data", bus.rf_wdata, 32'h22);
        chk("b2b_second_pc", bus.commit_pc, 32'h204);
        $display("back-to-back: second waddr=%0d wdata=%h pc=%h", bus.rf_waddr, bus.rf_wdata, bus.commit_pc);
        @(negedge clk);

`ifdef YSYX_25040105_WBU_BYPASS_EN
        fwd_raddr1 = 5'd7; fwd_raddr2 = 5'd0;
        fwd_rf_rdata1 = 32'h1111; fwd_rf_rdata2 = 32'h2222;
        bus.in_valid = 1'b1; bus.in_wen = 1'b1; bus.in_rd = 5'd7; bus.in_result = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("fwd1_commit", fwd_rdata1, 32'hA5);
        chk("fwd2_zero", fwd_rdata2, 32'h0);
        @(negedge clk);
        chk("fwd1_after", fwd_rdata1, 32'h1111);
        $display("bypass: fwd1=%h fwd2=%h", fwd_rdata1, fwd_rdata2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
